// File: rtl/spi_master_if.sv
// Bundle of the transfer handshake and the four serial pins of the SPI initiator.
// The master modport is the initiator's view; slave is the requester/pin side.
interface spi_master_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             done;
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;

    modport master (
        input  start, tx_data, miso,
        output rx_data, busy, done, sclk, cs_n, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  rx_data, busy, done, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master.sv
// Mode-0, MSB-first, full-duplex SPI initiator with a programmable SCLK half-period.
// Every output is a flop; the combinational process computes next values only.
module spi_master #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.master  bus
);
    localparam int DW = $clog2(CLKDIV) + 1;
    localparam int BW = $clog2(WIDTH) + 1;

    // state | meaning
    // IDLE  | cs_n high, waiting for start
    // SETUP | cs_n low, first bit on mosi before the first rising sclk
    // HIGH  | sclk high half-period
    // LOW   | sclk low half-period between bits
    // HOLD  | last falling edge done, cs_n still low before release
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    div_cnt, div_cnt_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] tx_shift, tx_shift_nxt;
    logic [WIDTH-1:0] rx_shift, rx_shift_nxt;
    logic [WIDTH-1:0] rx_data_q, rx_data_nxt;
    logic             sclk_q, sclk_nxt;
    logic             cs_n_q, cs_n_nxt;
    logic             mosi_q, mosi_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             last_div;

    assign last_div = (div_cnt == DW'(CLKDIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx_shift  <= tx_shift_nxt;
            rx_shift  <= rx_shift_nxt;
            rx_data_q <= rx_data_nxt;
            sclk_q    <= sclk_nxt;
            cs_n_q    <= cs_n_nxt;
            mosi_q    <= mosi_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        bit_cnt_nxt  = bit_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_data_nxt  = rx_data_q;
        sclk_nxt     = sclk_q;
        cs_n_nxt     = cs_n_q;
        mosi_nxt     = mosi_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    tx_shift_nxt = bus.tx_data;
                    mosi_nxt     = bus.tx_data[WIDTH-1];
                    cs_n_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    div_cnt_nxt  = '0;
                    bit_cnt_nxt  = '0;
                    state_nxt    = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (last_div) begin
                    // miso is captured on the clk edge that raises sclk
                    sclk_nxt     = 1'b1;
                    rx_shift_nxt = {rx_shift[WIDTH-2:0], bus.miso};
                    bit_cnt_nxt  = bit_cnt + 1'b1;
                    div_cnt_nxt  = '0;
                    state_nxt    = S_HIGH;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (last_div) begin
                    sclk_nxt    = 1'b0;
                    div_cnt_nxt = '0;
                    if (bit_cnt < BW'(WIDTH)) begin
                        tx_shift_nxt = {tx_shift[WIDTH-2:0], 1'b0};
                        mosi_nxt     = tx_shift[WIDTH-2];
                        state_nxt    = S_LOW;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (last_div) begin
                    cs_n_nxt    = 1'b1;
                    mosi_nxt    = 1'b0;
                    rx_data_nxt = rx_shift;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    div_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: instance a (CLKDIV=2) with loopback/constant miso,
// instance b (CLKDIV=4) against a shift-register peripheral model.
module tb_spi_master;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_master_if #(.WIDTH(8)) ia ();
    spi_master_if #(.WIDTH(8)) ib ();

    spi_master #(.WIDTH(8), .CLKDIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.master));
    spi_master #(.WIDTH(8), .CLKDIV(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // miso source for instance a: 0 = loopback from mosi, 1 = constant one
    int mode_a;
    assign ia.miso = (mode_a == 0) ? ia.mosi : 1'b1;

    // peripheral: samples mosi on sclk rise, shifts on sclk fall, MSB drives miso
    logic       periph_load;
    logic       periph_in;
    logic [7:0] periph_sr;
    always @(posedge ib.sclk) periph_in <= ib.mosi;
    always @(negedge ib.sclk or posedge periph_load) begin
        if (periph_load)  periph_sr <= 8'hA5;
        else if (!ib.cs_n) periph_sr <= {periph_sr[6:0], periph_in};
    end
    assign ib.miso = periph_sr[7];

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor counters, sampled on the falling clk edge
    int   rise_a, rise_b, done_a, done_b, busy_cyc_a, mosi_hi_a, hi_run_a, last_gap_a;
    logic prev_sclk_a, prev_sclk_b;
    initial begin
        rise_a = 0; rise_b = 0; done_a = 0; done_b = 0;
        busy_cyc_a = 0; mosi_hi_a = 0; hi_run_a = 0; last_gap_a = 0;
        prev_sclk_a = 1'b0; prev_sclk_b = 1'b0;
    end

    always @(negedge clk) begin
        if (ia.sclk === 1'b1 && prev_sclk_a === 1'b0) rise_a++;
        if (ib.sclk === 1'b1 && prev_sclk_b === 1'b0) rise_b++;
        prev_sclk_a = ia.sclk;
        prev_sclk_b = ib.sclk;
        if (ia.busy === 1'b1) busy_cyc_a++;
        if (ia.mosi === 1'b1) mosi_hi_a++;
        if (ia.cs_n === 1'b1) hi_run_a++;
        else begin
            if (hi_run_a > 0) last_gap_a = hi_run_a;
            hi_run_a = 0;
        end
        if (ia.done === 1'b1) begin
            done_a++;
            chk("a_sb_nonempty", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) chk("a_rx_data", 32'(ia.rx_data), 32'(q_a.pop_front()));
            chk("a_cs_n_on_done", 32'(ia.cs_n), 32'd1);
            chk("a_busy_on_done", 32'(ia.busy), 32'd0);
        end
        if (ib.done === 1'b1) begin
            done_b++;
            chk("b_sb_nonempty", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) chk("b_rx_data", 32'(ib.rx_data), 32'(q_b.pop_front()));
        end
    end

    task automatic start_a(input logic [7:0] data);
        @(negedge clk);
        ia.start   = 1'b1;
        ia.tx_data = data;
        @(posedge clk);
        #1;
        ia.start   = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ia.done === 1'b1) break;
        end
    endtask

    task automatic wait_done_b(output int n);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (ib.done === 1'b1) break;
        end
    endtask

    int n;
    int d0;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        mode_a = 0;
        periph_load = 1'b0;
        ia.start = 1'b0; ia.tx_data = 8'h00;
        ib.start = 1'b0; ib.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(ia.sclk), 32'd0);
        chk("rst_cs_n", 32'(ia.cs_n), 32'd1);
        chk("rst_mosi", 32'(ia.mosi), 32'd0);
        chk("rst_busy", 32'(ia.busy), 32'd0);
        chk("rst_done", 32'(ia.done), 32'd0);
        chk("rst_rx_data", 32'(ia.rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // loopback A5
        rise_a = 0;
        q_a.push_back(8'hA5);
        start_a(8'hA5);
        wait_done_a(n);
        chk("t1_latency", 32'(n), 32'd34);
        chk("t1_cs_n_done", 32'(ia.cs_n), 32'd1);
        @(negedge clk);
        chk("t1_rises", 32'(rise_a), 32'd8);

        // miso tied high, tx 00
        mode_a = 1;
        busy_cyc_a = 0;
        mosi_hi_a = 0;
        q_a.push_back(8'hFF);
        start_a(8'h00);
        wait_done_a(n);
        chk("t2_latency", 32'(n), 32'd34);
        chk("t2_busy_cycles", 32'(busy_cyc_a), 32'd34);
        chk("t2_mosi_high_cycles", 32'(mosi_hi_a), 32'd0);
        mode_a = 0;

        // peripheral model on instance b
        @(negedge clk);
        periph_load = 1'b1;
        @(negedge clk);
        periph_load = 1'b0;
        rise_b = 0;
        q_b.push_back(8'hA5);
        @(negedge clk);
        ib.start = 1'b1;
        ib.tx_data = 8'h3C;
        @(posedge clk);
        #1;
        ib.start = 1'b0;
        ib.tx_data = 8'h00;
        wait_done_b(n);
        chk("t3_latency", 32'(n), 32'd68);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_periph_word", 32'(periph_sr), 32'h3C);
        chk("t3_rises", 32'(rise_b), 32'd8);

        // start while busy is ignored
        d0 = done_a;
        q_a.push_back(8'h3C);
        start_a(8'h3C);
        repeat (9) @(negedge clk);
        ia.start = 1'b1;
        ia.tx_data = 8'hFF;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        wait_done_a(n);
        chk("t4_done_seen", 32'(n < 200), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_done_count", 32'(done_a - d0), 32'd1);

        // start held high: back-to-back transfers
        d0 = done_a;
        repeat (3) q_a.push_back(8'h5A);
        @(negedge clk);
        ia.start = 1'b1;
        ia.tx_data = 8'h5A;
        @(posedge clk);
        #1;
        wait_done_a(n);
        chk("t5_latency_1", 32'(n), 32'd34);
        wait_done_a(n);
        chk("t5_latency_2", 32'(n), 32'd35);
        chk("t5_cs_n_gap", 32'(last_gap_a), 32'd1);
        wait_done_a(n);
        ia.start = 1'b0;
        chk("t5_latency_3", 32'(n), 32'd35);
        repeat (40) @(posedge clk);
        #1;
        chk("t5_done_count", 32'(done_a - d0), 32'd3);
        chk("t5_sb_drained", 32'(q_a.size()), 32'd0);

        // asynchronous reset after the third rising sclk
        rise_a = 0;
        d0 = done_a;
        q_a.push_back(8'h96);
        start_a(8'h96);
        repeat (10) @(posedge clk);
        #6;
        chk("t6_pre_sclk", 32'(ia.sclk), 32'd1);
        chk("t6_pre_rises", 32'(rise_a), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_sclk", 32'(ia.sclk), 32'd0);
        chk("t6_cs_n", 32'(ia.cs_n), 32'd1);
        chk("t6_mosi", 32'(ia.mosi), 32'd0);
        chk("t6_busy", 32'(ia.busy), 32'd0);
        chk("t6_rx_data", 32'(ia.rx_data), 32'd0);
        q_a.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(done_a - d0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q_a.push_back(8'hC3);
        start_a(8'hC3);
        wait_done_a(n);
        chk("t6_restart_latency", 32'(n), 32'd34);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_restart_rx", 32'(ia.rx_data), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Serial-peripheral initiator. It drives the serial clock, the active-low chip select and the outbound data line toward a shiftregister-style peripheral, and it captures that peripheral's return data.
- The peripheral samples its serial input on SCLK rising edges and shifts on SCLK falling edges. This block is the controlling end of that link.
- It sits in the top level between the switch/button logic (which requests a transfer) and the gpio bank pins.
- Transfers are full duplex and MSB first. SCLK idles low (mode 0).

Parameters:
- WIDTH, 8: bits per transfer; width of txData and rxData.
- CLKDIV, 4: clk cycles per SCLK half-period. Minimum 1. Must exceed the peripheral's input-conditioning latency.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  transfer request; sampled only in IDLE
- txData  input  WIDTH  word to send; captured on the cycle start is accepted
- rxData  output  WIDTH  last completed received word
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle pulse when a transfer completes
- sclk  output  1  serial clock to the peripheral
- cs_n  output  1  active-low chip select
- mosi  output  1  serial data to the peripheral
- miso  input  1  serial data from the peripheral; assumed synchronous or slow relative to clk

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - sclk=0, cs_n=1, mosi=0, busy=0, done=0, rxData=0.
  - Internal shift registers, divider counter and bit counter are cleared.
- Reset asserted mid-transfer: the outputs above apply immediately. No done pulse is produced and rxData is not updated.
- All outputs are registered.
- States: IDLE, SETUP, HIGH, LOW, HOLD.
- IDLE:
  - busy=0, cs_n=1, sclk=0.
  - start=1 on a clk edge: txData is loaded into txShift; next state is SETUP.
  - On that same edge: cs_n<=0, mosi<=txData[WIDTH-1], busy<=1, divider cleared, bit counter cleared.
- SETUP:
  - Holds for CLKDIV cycles with sclk=0, giving data setup before the first rising edge.
  - On the final cycle: sclk<=1, rxShift<={rxShift[WIDTH-2:0], miso}, bit counter increments; next state is HIGH.
- HIGH:
  - Holds for CLKDIV cycles with sclk=1.
  - On the final cycle sclk<=0 in both cases below.
  - If bit counter < WIDTH: txShift shifts left by one, mosi<=new MSB; next state is LOW.
  - Otherwise: next state is HOLD; mosi holds its value.
- LOW:
  - Holds for CLKDIV cycles with sclk=0.
  - On the final cycle: sclk<=1, miso is sampled into rxShift as in SETUP, bit counter increments; next state is HIGH.
- HOLD:
  - Holds for CLKDIV cycles with sclk=0 and cs_n=0.
  - On the final cycle: cs_n<=1, mosi<=0, rxData<=rxShift, done<=1, busy<=0; next state is IDLE.
- done is high for exactly one cycle.
- Timing:
  - Exactly WIDTH SCLK rising edges per transfer, and WIDTH falling edges (the last one leads into HOLD).
  - The first bit is sampled on rising edge 1; the received word is MSB first.
  - Latency: done rises CLKDIV*(2*WIDTH+1) cycles after the edge that accepted start.
  - With WIDTH=8, CLKDIV=4 that is 68 cycles.
- start while busy is ignored; it is neither queued nor an error.
- start high on the done cycle:
  - State is IDLE in the following cycle, so a start held high in that cycle begins a new transfer.
  - cs_n is high for at least one cycle between transfers.
- txData changes after acceptance have no effect on the transfer in progress.
- rxData holds its value between transfers and during a transfer. It changes only on done.
- Counters:
  - Divider counter width is $clog2(CLKDIV)+1.
  - Bit counter width is $clog2(WIDTH)+1.
  - Neither counter wraps within a transfer.

Test Plan:
- Loopback (mosi tied to miso), WIDTH=8, CLKDIV=2, txData=0xA5, start pulse -> 8 sclk rising edges; done pulse 34 cycles after the accept edge; rxData=0xA5; cs_n high again on the done cycle.
- miso tied to 1, txData=0x00 -> rxData=0xFF; mosi stays 0 for the whole transfer; busy high for 34 cycles.
- Model peripheral (0xA5 parallel-loaded, shifts on sclk falling edge), txData=0x3C, CLKDIV=4 -> rxData=0xA5; peripheral's parallel output reads 0x3C after cs_n rises.
- start pulsed again at cycle 10 of a transfer with txData=0xFF -> ignored; the current transfer completes with the original data; exactly one done pulse.
- start held high continuously with loopback, txData=0x5A -> back-to-back transfers; cs_n high for at least 1 cycle between them; each done pulse has rxData=0x5A.
- rst_n driven low after the 3rd sclk rising edge -> sclk=0, cs_n=1, mosi=0, busy=0 asynchronously; no done pulse; rxData keeps its prior value 0 (from reset); a new start after release completes normally.
